// File: rtl/reaction_timer.sv
`default_nettype none
// ============================================================================
// Module      : reaction_timer
// Description : Measures one reaction-time trial in milliseconds. A random
//               hold-off (MIN_DELAY_MS plus masked LFSR value) precedes the
//               LED stimulus; the time from LED-on to the button press edge
//               is reported as an unsigned 13-bit ms value with a one-cycle
//               valid pulse. Pressing before the LED lights is a foul.
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous reset, active-high
//               start    - begins a trial when not busy
//               button   - debounced player button
//               led      - stimulus lit (ARMED)
//               busy     - trial in progress (WAIT or ARMED)
//               time_ms  - last result in ms, held until the next result
//               valid    - one-cycle pulse when time_ms updates
//               foul     - held high after an early press
//               best_ms  - smallest valid result since reset (BEST_TIME_EN)
// Config      : define BEST_TIME_EN to add the best_ms output and register.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_timer #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter logic [12:0] MIN_DELAY_MS = 13'd1000,
  parameter logic [12:0] DELAY_MASK   = 13'h7FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        button,
  output logic        led,
  output logic        busy,
  output logic [12:0] time_ms,
  output logic        valid,
`ifdef BEST_TIME_EN
  output logic        foul,
  output logic [12:0] best_ms
`else
  output logic        foul
`endif
);

  localparam int unsigned      PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [12:0]      LFSR_SEED = 13'h1ACE;
  localparam logic [12:0]      MS_MAX    = 13'h1FFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ARMED = 3'd2,
    S_DONE  = 3'd3,
    S_FOUL  = 3'd4
  } state_t;

  state_t           state;
  logic [12:0]      lfsr;
  logic [12:0]      delay;
  logic [12:0]      ms_cnt;
  logic [PRE_W-1:0] prescaler;
  logic             button_q;

  logic             tick;
  logic             press;
  logic             lfsr_fb;
  logic [12:0]      ms_next;

  assign tick    = (prescaler == PRE_LAST);
  assign press   = button & ~button_q;
  // Taps for x^13 + x^4 + x^3 + x + 1
  assign lfsr_fb = lfsr[12] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0];
  // Count value after this cycle; expiry and saturation are judged on it so the
  // transition lands on the same edge as the tick that completes the interval.
  assign ms_next = ms_cnt + {12'd0, tick};

  always_ff @(posedge clk) begin
    button_q <= button;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      led       <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      foul      <= 1'b0;
      time_ms   <= 13'd0;
      lfsr      <= LFSR_SEED;
      prescaler <= '0;
      ms_cnt    <= 13'd0;
      delay     <= 13'd0;
    end else begin
      lfsr      <= {lfsr[11:0], lfsr_fb};
      valid     <= 1'b0;
      prescaler <= tick ? '0 : prescaler + 1'b1;

      case (state)
        S_IDLE, S_DONE, S_FOUL: begin
          if (start) begin
            state     <= S_WAIT;
            busy      <= 1'b1;
            foul      <= 1'b0;
            delay     <= MIN_DELAY_MS + (lfsr & DELAY_MASK);
            ms_cnt    <= 13'd0;
            prescaler <= '0;
          end
        end

        S_WAIT: begin
          // An early press wins over a simultaneous hold-off expiry.
          if (press) begin
            state     <= S_FOUL;
            busy      <= 1'b0;
            foul      <= 1'b1;
            prescaler <= '0;
          end else if (ms_next == delay) begin
            state     <= S_ARMED;
            led       <= 1'b1;
            ms_cnt    <= 13'd0;
            prescaler <= '0;
          end else begin
            ms_cnt <= ms_next;
          end
        end

        S_ARMED: begin
          // On a coincident tick the pre-increment count is the result.
          if (press) begin
            state     <= S_DONE;
            led       <= 1'b0;
            busy      <= 1'b0;
            time_ms   <= ms_cnt;
            valid     <= 1'b1;
            prescaler <= '0;
          end else if (ms_next == MS_MAX) begin
            state     <= S_DONE;
            led       <= 1'b0;
            busy      <= 1'b0;
            ms_cnt    <= ms_next;
            time_ms   <= MS_MAX;
            valid     <= 1'b1;
            prescaler <= '0;
          end else begin
            ms_cnt <= ms_next;
          end
        end

        default: begin
          state <= S_IDLE;
          led   <= 1'b0;
          busy  <= 1'b0;
          foul  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BEST_TIME_EN
  // Follows valid by one cycle; a saturated 8191 can never go below the
  // 13'h1FFF starting value.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_ms <= MS_MAX;
    end else if (valid && (time_ms < best_ms)) begin
      best_ms <= time_ms;
    end
  end
`endif

endmodule

`default_nettype wire
